// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter
// ------------
// Shares one single-port data memory between two requesters: port 0 is the
// core load/store unit, port 1 is the DMA / program loader. One transaction
// is outstanding at a time; ports are picked round-robin, the access is held
// on the memory bus for MEM_LAT cycles, and a one-cycle response pulse is
// returned to the port that was granted.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req/we/addr/wdata/maskN  request + command from port N (held until gntN)
//   gntN                     combinational accept strobe, only in IDLE
//   rvalidN                  one-cycle response pulse to port N
//   rdata, err               response payload, valid with rvalid (else 0)
//   mem_cs                   memory chip select, active low
//   mem_rd_wr                1 = read, 0 = write
//   mem_addr/wdata/mask      memory command
//   mem_rdata                memory read data, valid in the last access cycle
module dmem_arbiter #(
  parameter int unsigned MEM_LAT = 1,   // 1..15
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  input  logic [3:0]    mask0,
  input  logic [3:0]    mask1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          mem_cs,
  output logic          mem_rd_wr,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_mask,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [3:0]    count_q, count_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    mask_q, mask_d;
  logic          port_q, port_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  // Only naturally aligned byte, halfword and word lanes are writable.
  function automatic logic mask_legal(input logic [3:0] m);
    case (m)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: mask_legal = 1'b1;
      default:                   mask_legal = 1'b0;
    endcase
  endfunction

  // Arbitration: a lone requester wins; on a tie the port that did not win
  // last time goes first.
  logic          any_req;
  logic          winner;
  logic          accept;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_mask;

  assign any_req   = req0 | req1;
  assign winner    = (req0 & req1) ? ~last_q : req1;
  // Gated with rst so no grant is visible while the block is held in reset.
  assign accept    = (state_q == IDLE) & any_req & ~rst;
  assign gnt0      = accept & ~winner;
  assign gnt1      = accept & winner;
  assign sel_we    = winner ? we1    : we0;
  assign sel_addr  = winner ? addr1  : addr0;
  assign sel_wdata = winner ? wdata1 : wdata0;
  assign sel_mask  = winner ? mask1  : mask0;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    last_d    = last_q;
    count_d   = count_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    port_d    = port_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata_d   = '0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          mask_d  = sel_mask;
          port_d  = winner;
          last_d  = winner;
          if (sel_we && !mask_legal(sel_mask)) begin
            // Rejected write never touches memory; respond next cycle.
            state_d   = RESP;
            err_d     = 1'b1;
            rvalid0_d = ~winner;
            rvalid1_d = winner;
          end else begin
            state_d = ACCESS;
            count_d = CNT_INIT;
          end
        end
      end
      ACCESS: begin
        if (count_q == 4'd0) begin
          state_d   = RESP;
          rvalid0_d = ~port_q;
          rvalid1_d = port_q;
          rdata_d   = we_q ? 32'h0 : mem_rdata;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      count_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      port_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      count_q   <= count_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      port_q    <= port_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = rdata_q;
  assign err     = err_q;

  // Memory strobes decode straight from the state flop, so an asynchronous
  // reset drops chip select at once without waiting for a clock edge.
  assign mem_cs    = (state_q != ACCESS);
  assign mem_rd_wr = (state_q == ACCESS) ? ~we_q : 1'b1;
  assign mem_mask  = (state_q != ACCESS) ? 4'h0 : (we_q ? mask_q : 4'hF);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for dmem_arbiter: table-driven transactions on an
// MEM_LAT=2 instance with a scoreboard and a behavioural memory, hand-written
// sequences for round-robin, reset during an access, and an MEM_LAT=1
// instance for back-to-back timing.
module tb_dmem_arbiter;

  localparam int unsigned LAT = 2;
  localparam int unsigned AW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---- MEM_LAT=2 instance -------------------------------------------------
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic [3:0]    mask0, mask1;
  logic          gnt0, gnt1, rvalid0, rvalid1, err;
  logic [31:0]   rdata;
  logic          mem_cs, mem_rd_wr;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_mask;

  dmem_arbiter #(.MEM_LAT(LAT), .AW(AW)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .mask0(mask0), .mask1(mask1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .err(err),
    .mem_cs(mem_cs), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata)
  );

  // ---- MEM_LAT=1 instance -------------------------------------------------
  logic          rst_b;
  logic          req0_b, req1_b, we0_b, we1_b;
  logic [AW-1:0] addr0_b, addr1_b;
  logic [31:0]   wdata0_b, wdata1_b;
  logic [3:0]    mask0_b, mask1_b;
  logic          gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, err_b;
  logic [31:0]   rdata_b;
  logic          mem_cs_b, mem_rd_wr_b;
  logic [AW-1:0] mem_addr_b;
  logic [31:0]   mem_wdata_b, mem_rdata_b;
  logic [3:0]    mem_mask_b;

  dmem_arbiter #(.MEM_LAT(1), .AW(AW)) u_dut1 (
    .clk(clk), .rst(rst_b),
    .req0(req0_b), .req1(req1_b), .we0(we0_b), .we1(we1_b),
    .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
    .mask0(mask0_b), .mask1(mask1_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .rvalid0(rvalid0_b), .rvalid1(rvalid1_b),
    .rdata(rdata_b), .err(err_b),
    .mem_cs(mem_cs_b), .mem_rd_wr(mem_rd_wr_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_mask(mem_mask_b), .mem_rdata(mem_rdata_b)
  );

  // ---- bookkeeping ----------------------------------------------------------
  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask,
                          input logic [31:0] rd, input logic e);
    exp_t x;
    x.port = port; x.we = we; x.addr = addr; x.wdata = wdata;
    x.mask = mask; x.rdata = rd; x.err = e;
    exp_q.push_back(x);
  endtask

  // ---- behavioural memory for the MEM_LAT=2 instance ------------------------
  logic [31:0] mem [256];
  int          mem_run = 0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hDEADBEEF;   // 0x100
    mem[8'h81] = 32'h11223344;   // 0x204
    mem[8'h42] = 32'h55667788;   // 0x108
    mem[8'h44] = 32'h99999999;   // 0x110
    mem_rdata  = 32'h5A5A5A5A;
    forever begin
      @(posedge clk); #1;
      if (rst || mem_cs) mem_run = 0;
      else               mem_run++;
      // Read data only appears in the last access cycle; otherwise filler.
      if (!mem_cs && mem_run == LAT) begin
        if (mem_rd_wr) mem_rdata = mem[mem_addr[9:2]];
        else begin
          for (int b = 0; b < 4; b++)
            if (mem_mask[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          mem_rdata = 32'h5A5A5A5A;
        end
      end else begin
        mem_rdata = 32'h5A5A5A5A;
      end
    end
  end

  // ---- monitor / scoreboard for the MEM_LAT=2 instance ----------------------
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt0 | gnt1)
        check("gnt_only_idle_onehot", {29'b0, gnt0 & gnt1, ~mem_cs, rvalid0 | rvalid1}, 32'h0);
      if (!mem_cs) begin
        if (exp_q.size() == 0) check("cs_without_txn", 32'h1, 32'h0);
        else begin
          mon_e = exp_q[0];
          check("cs_on_rejected_write", {31'b0, mon_e.err}, 32'h0);
          check("mem_rd_wr", {31'b0, mem_rd_wr}, {31'b0, ~mon_e.we});
          check("mem_mask", {28'b0, mem_mask}, {28'b0, mon_e.we ? mon_e.mask : 4'hF});
          check("mem_addr", mem_addr, mon_e.addr);
          if (mon_e.we) check("mem_wdata", mem_wdata, mon_e.wdata);
        end
      end else begin
        check("mem_idle_strobes", {27'b0, mem_rd_wr, mem_mask}, {27'b0, 1'b1, 4'h0});
      end
      if (rvalid0 | rvalid1) begin
        if (exp_q.size() == 0) check("rvalid_without_txn", 32'h1, 32'h0);
        else begin
          mon_e = exp_q.pop_front();
          check("rvalid_port", {30'b0, rvalid0, rvalid1}, mon_e.port ? 32'h1 : 32'h2);
          check("rdata", rdata, mon_e.rdata);
          check("err", {31'b0, err}, {31'b0, mon_e.err});
        end
      end else begin
        check("rdata_idle_zero", rdata, 32'h0);
        check("err_idle_zero", {31'b0, err}, 32'h0);
      end
    end
  end

  // ---- one table-driven transaction -----------------------------------------
  task automatic do_txn(input vec_t v);
    bit seen;
    int lat;
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    if (v.port) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; mask1 = v.mask;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; mask0 = v.mask;
    end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (v.port ? gnt1 : gnt0) seen = 1'b1;
    end
    check("gnt_seen", {31'b0, seen}, 32'h1);
    if (!seen) begin
      req0 = 1'b0; req1 = 1'b0;
      return;
    end
    check("gnt_other_low", {31'b0, v.port ? gnt0 : gnt1}, 32'h0);
    push_exp(v.port, v.we, v.addr, v.wdata, v.mask, v.exp_rdata, v.exp_err);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    seen = 1'b0; lat = 1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (rvalid0 | rvalid1) seen = 1'b1;
      else lat++;
    end
    check("gnt_to_rvalid", lat, v.exp_err ? 32'd1 : LAT + 1);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(negedge clk);
    check(name, exp_q.size(), 32'h0);
  endtask

  vec_t vecs[13];

  // Global time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int gcyc, rvcyc;

    //           port  we    addr        wdata         mask     exp_rdata     err
    vecs[0]  = '{1'b0, 1'b0, 32'h100, 32'h00000000, 4'b0000, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 32'h204, 32'h0000AB00, 4'b0010, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h204, 32'h00000000, 4'b0000, 32'h1122AB44, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h100, 32'h12345678, 4'b0110, 32'h00000000, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 32'h100, 32'hFFFFFFFF, 4'b0000, 32'h00000000, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 32'h108, 32'hCAFE0000, 4'b1100, 32'h00000000, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h108, 32'h00000000, 4'b0000, 32'hCAFE7788, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h10C, 32'h0BADC0DE, 4'b1111, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h10C, 32'h00000000, 4'b0000, 32'h0BADC0DE, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h100, 32'h00000000, 4'b1010, 32'h00000000, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h100, 32'h00000000, 4'b0000, 32'hDEADBEEF, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h110, 32'h000000EE, 4'b0001, 32'h00000000, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h110, 32'h00000000, 4'b0000, 32'h999999EE, 1'b0};

    rst = 1'b1; rst_b = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; mask0 = '0; mask1 = '0;
    req0_b = 0; req1_b = 0; we0_b = 0; we1_b = 0; addr0_b = '0; addr1_b = '0;
    wdata0_b = '0; wdata1_b = '0; mask0_b = '0; mask1_b = '0;
    mem_rdata_b = 32'h12345678;

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset_ctrl", {22'b0, gnt0, gnt1, rvalid0, rvalid1, err, mem_cs, mem_rd_wr, mem_mask},
          {22'b0, 5'b00000, 1'b1, 1'b1, 4'h0});
    check("reset_rdata", rdata, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; rst_b = 1'b0;

    // Table-driven single-requester transactions.
    for (int i = 0; i < 13; i++) do_txn(vecs[i]);
    drain("table_drain");

    // Both ports requesting continuously from reset: grants alternate 0,1,0,1.
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100; mask0 = 4'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10C; mask1 = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (gnt0 | gnt1) seen = 1'b1;
      end
      check("rr_gnt_seen", {31'b0, seen}, 32'h1);
      check("rr_order", {30'b0, gnt0, gnt1}, (g % 2 == 1) ? 32'h1 : 32'h2);
      if (gnt1) push_exp(1'b1, 1'b0, 32'h10C, 32'h0, 4'h0, 32'h0BADC0DE, 1'b0);
      else      push_exp(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    drain("rr_drain");

    // Reset during the first ACCESS cycle of a read: chip select drops at
    // once, no response, and a held req1 is served first afterwards.
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (gnt0) seen = 1'b1;
    end
    check("abort_gnt0_seen", {31'b0, seen}, 32'h1);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h108;
    check("abort_cs_in_access", {31'b0, mem_cs}, 32'h0);
    #1 rst = 1'b1;
    #1;
    check("abort_cs_async", {31'b0, mem_cs}, 32'h1);
    check("abort_no_rvalid", {30'b0, rvalid0, rvalid1}, 32'h0);
    repeat (2) @(negedge clk);
    check("abort_in_reset", {29'b0, rvalid0, rvalid1, gnt1}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (gnt0 | gnt1) seen = 1'b1;
    end
    check("post_reset_gnt", {30'b0, gnt0, gnt1}, 32'h1);
    if (gnt1) push_exp(1'b1, 1'b0, 32'h108, 32'h0, 4'h0, 32'hCAFE7788, 1'b0);
    @(posedge clk); #1;
    req1 = 1'b0;
    drain("abort_drain");

    // MEM_LAT=1: read then an immediate write from port 0.
    @(posedge clk); #1;
    req0_b = 1'b1; we0_b = 1'b0; addr0_b = 32'h40; mask0_b = 4'h0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (gnt0_b) seen = 1'b1;
    end
    check("lat1_gnt_seen", {31'b0, seen}, 32'h1);
    @(posedge clk); #1;
    we0_b = 1'b1; wdata0_b = 32'h000000A5; mask0_b = 4'b0001;
    gcyc = -1; rvcyc = -1;
    for (int c = 1; c <= 8 && gcyc < 0; c++) begin
      @(negedge clk);
      if (rvalid0_b && rvcyc < 0) begin
        rvcyc = c;
        check("lat1_read_rdata", rdata_b, 32'h12345678);
        check("lat1_read_err", {31'b0, err_b}, 32'h0);
      end
      if (gnt0_b) gcyc = c;
    end
    check("lat1_rvalid_cycle", rvcyc, 32'd2);
    check("lat1_second_gnt_cycle", gcyc, 32'd3);
    @(posedge clk); #1;
    req0_b = 1'b0;
    @(negedge clk);
    check("lat1_write_strobes", {26'b0, mem_cs_b, mem_rd_wr_b, mem_mask_b}, {26'b0, 2'b00, 4'b0001});
    check("lat1_write_bus", mem_wdata_b, 32'h000000A5);
    @(negedge clk);
    check("lat1_write_resp", {29'b0, rvalid0_b, rvalid1_b, err_b}, 32'h4);
    check("lat1_write_rdata", rdata_b, 32'h0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
